// File: rtl/regfile_pkg.sv
// Shared widths, constants, request record and arbitration state
// for the register-file writeback arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant with a single priority pointer flop.
// Grants are combinational from valids and pointer; no grant while in reset.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic valid_a,
  input  logic valid_b,
  output logic grant_a,
  output logic grant_b
);
  import regfile_pkg::*;

  rr_state_t state_q;
  rr_state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRI_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    state_d = state_q;
    // Reset aborts any handshake, so nothing is accepted while it is high.
    if (!rst) begin
      if (valid_a && (!valid_b || state_q == PRI_A)) begin
        grant_a = 1'b1;
      end else if (valid_b) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      state_d = PRI_B;
    end else if (grant_b) begin
      state_d = PRI_A;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the regfile write port (1-cycle registered) plus a pending-write scoreboard.
// Ready is combinational; REGFILE_WB_STATS_EN adds saturating grant/conflict counters.
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
`ifdef REGFILE_WB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           AValid,
  output logic                           AReady,
  input  logic [ADDR_W-1:0]              AAddr,
  input  logic [DATA_W-1:0]              AData,
  input  logic                           BValid,
  output logic                           BReady,
  input  logic [ADDR_W-1:0]              BAddr,
  input  logic [DATA_W-1:0]              BData,
  input  logic                           Reserve,
  input  logic [ADDR_W-1:0]              ReserveAddr,
  output logic                           RegWrite,
  output logic [ADDR_W-1:0]              WriteRegister,
  output logic [DATA_W-1:0]              WriteData,
  output logic [regfile_pkg::NUM_REGS-1:0] PendingMask
`ifdef REGFILE_WB_STATS_EN
  ,
  input  logic                           StatsClear,
  output logic [CNT_W-1:0]               AGrantCount,
  output logic [CNT_W-1:0]               BGrantCount,
  output logic [CNT_W-1:0]               ConflictCount
`endif
);
  import regfile_pkg::*;

  wb_req_t req_a;
  wb_req_t req_b;
  wb_req_t winner;
  logic    grant_a;
  logic    grant_b;
  logic    grant;

  logic [NUM_REGS-1:0] pending_d;

  assign req_a = '{valid: AValid, addr: AAddr, data: AData};
  assign req_b = '{valid: BValid, addr: BAddr, data: BData};

  rr_arbiter2 u_arb (
    .clk     (Clk),
    .rst     (Reset),
    .valid_a (req_a.valid),
    .valid_b (req_b.valid),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign AReady = grant_a;
  assign BReady = grant_b;
  assign grant  = grant_a | grant_b;
  assign winner = grant_b ? req_b : req_a;

  // A write to r0 is consumed but never reaches the regfile.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (grant) begin
      RegWrite      <= (winner.addr != ZERO_REG);
      WriteRegister <= winner.addr;
      WriteData     <= winner.data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  // Clear first, then set, so a same-cycle reservation of the written register survives.
  always_comb begin
    pending_d = PendingMask;
    if (grant) begin
      pending_d[winner.addr] = 1'b0;
    end
    if (Reserve && (ReserveAddr != ZERO_REG)) begin
      pending_d[ReserveAddr] = 1'b1;
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PendingMask <= '0;
    end else begin
      PendingMask <= pending_d;
    end
  end

`ifdef REGFILE_WB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      AGrantCount   <= '0;
      BGrantCount   <= '0;
      ConflictCount <= '0;
    end else if (StatsClear) begin
      AGrantCount   <= '0;
      BGrantCount   <= '0;
      ConflictCount <= '0;
    end else begin
      if (grant_a && (AGrantCount != CNT_MAX)) begin
        AGrantCount <= AGrantCount + 1'b1;
      end
      if (grant_b && (BGrantCount != CNT_MAX)) begin
        BGrantCount <= BGrantCount + 1'b1;
      end
      if (AValid && BValid && (ConflictCount != CNT_MAX)) begin
        ConflictCount <= ConflictCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed checks of regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        AValid = 1'b0, BValid = 1'b0, Reserve = 1'b0;
  logic        AReady, BReady, RegWrite;
  logic [4:0]  AAddr = '0, BAddr = '0, ReserveAddr = '0, WriteRegister;
  logic [31:0] AData = '0, BData = '0, WriteData, PendingMask;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: who is favoured, what the regfile port should show.
  logic        fav_a = 1'b1;
  logic        exp_rw = 1'b0;
  logic [4:0]  exp_wr = '0;
  logic [31:0] exp_wd = '0;
  logic [31:0] exp_pm = '0;

  logic        ga, gb;
  int          na, nb;
  logic        a_pend, b_pend;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
    .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
    .Reserve(Reserve), .ReserveAddr(ReserveAddr),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .PendingMask(PendingMask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".regwrite"}, 32'(RegWrite), 32'(exp_rw));
    chk({tag, ".wreg"}, 32'(WriteRegister), 32'(exp_wr));
    chk({tag, ".wdata"}, WriteData, exp_wd);
    chk({tag, ".pending"}, PendingMask, exp_pm);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    AValid = 1'b0; BValid = 1'b0; Reserve = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    fav_a = 1'b1; exp_rw = 1'b0; exp_wr = '0; exp_wd = '0; exp_pm = '0;
  endtask

  // One cycle: drive just after a falling edge, check Ready, advance, check the port.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic res, input logic [4:0] ra,
                      output logic oga, output logic ogb);
    logic [4:0] w;
    AValid = av; AAddr = aa; AData = ad;
    BValid = bv; BAddr = ba; BData = bd;
    Reserve = res; ReserveAddr = ra;
    #1;
    oga = av && (!bv || fav_a);
    ogb = bv && !oga;
    chk("a_ready", 32'(AReady), 32'(oga));
    chk("b_ready", 32'(BReady), 32'(ogb));
    chk("ready_excl", 32'(AReady & BReady), 32'd0);
    @(posedge Clk);
    if (oga || ogb) begin
      w = oga ? aa : ba;
      exp_wr = w;
      exp_wd = oga ? ad : bd;
      exp_rw = (w != 5'd0);
      exp_pm[w] = 1'b0;
      fav_a = ogb;
    end else begin
      exp_rw = 1'b0;
    end
    if (res && ra != 5'd0) exp_pm[ra] = 1'b1;
    @(negedge Clk);
    check_outs("port");
  endtask

  initial begin
    #12;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_wreg", 32'(WriteRegister), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_pending", PendingMask, 32'd0);
    do_reset();

    // Single A write, then idle.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ga, gb);
    chk("a_only_grant", 32'(ga), 32'd1);
    chk("a_only_data", WriteData, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ga, gb);
    chk("a_only_idle_rw", 32'(RegWrite), 32'd0);

    // Both held from reset: A first, then B.
    do_reset();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, ga, gb);
    chk("both_first_a", 32'(ga), 32'd1);
    chk("both_first_reg", 32'(WriteRegister), 32'd3);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, ga, gb);
    chk("both_second_b", 32'(gb), 32'd1);
    chk("both_second_data", WriteData, 32'h22);

    // Sustained contention: strict alternation.
    na = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom,
           1'b0, 5'd0, ga, gb);
      if (ga) na++;
      if (gb) nb++;
    end
    chk("alt_a_count", 32'(na), 32'd5);
    chk("alt_b_count", 32'(nb), 32'd5);

    // Scoreboard set, clear, and set-wins.
    do_reset();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, ga, gb);
    chk("sb_set7", 32'(PendingMask[7]), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, ga, gb);
    chk("sb_clear7", 32'(PendingMask[7]), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, ga, gb);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7, ga, gb);
    chk("sb_setwins7", 32'(PendingMask[7]), 32'd1);

    // Register zero: consumed, never written, never pending.
    do_reset();
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, ga, gb);
    chk("r0_ready", 32'(ga), 32'd1);
    chk("r0_regwrite", 32'(RegWrite), 32'd0);
    chk("r0_pending", PendingMask, 32'd0);

    // Randomized traffic honouring hold-until-ready.
    a_pend = 1'b0; b_pend = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!a_pend) begin
        a_pend = ($urandom_range(0, 2) != 0);
        a_addr = 5'($urandom_range(0, 31));
        a_data = $urandom;
      end
      if (!b_pend) begin
        b_pend = ($urandom_range(0, 2) != 0);
        b_addr = 5'($urandom_range(0, 31));
        b_data = $urandom;
      end
      step(a_pend, a_addr, a_data, b_pend, b_addr, b_data,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), ga, gb);
      if (ga) a_pend = 1'b0;
      if (gb) b_pend = 1'b0;
    end

    // Asynchronous reset in mid-operation with both requesters valid.
    do_reset();
    for (int r = 4; r < 8; r++) begin
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), ga, gb);
    end
    step(1'b1, 5'd9, 32'hCAFE0009, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ga, gb);
    chk("pre_rst_pending", PendingMask, 32'h000000F0);
    AValid = 1'b1; AAddr = 5'd1; AData = 32'h1;
    BValid = 1'b1; BAddr = 5'd2; BData = 32'h2;
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_regwrite", 32'(RegWrite), 32'd0);
    chk("arst_wreg", 32'(WriteRegister), 32'd0);
    chk("arst_wdata", WriteData, 32'd0);
    chk("arst_pending", PendingMask, 32'd0);
    chk("arst_aready", 32'(AReady), 32'd0);
    chk("arst_bready", 32'(BReady), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    fav_a = 1'b1; exp_rw = 1'b0; exp_wr = '0; exp_wd = '0; exp_pm = '0;
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, ga, gb);
    chk("post_rst_a_first", 32'(ga), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
